// File: rtl/ram_req_ctrl_if.sv
// Request/response handshake bundle between an upstream client and ram_req_ctrl.
// The controller uses the slave modport; the client side uses master.
interface ram_req_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (output req_valid, req_we, req_addr, req_wdata, rsp_ready,
                    input  req_ready, rsp_valid, rsp_rdata);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
                    output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/ram_req_ctrl.sv
// In-order RAM request controller: clears the RAM after reset, then queues requests
// and issues one RAM op per cycle. Optional counters under RAM_REQ_CTRL_STATS_EN.
module ram_req_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int REQ_DEPTH  = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_req_ctrl_if.slave         bus,
    output logic                  ram_write_enb,
    output logic                  ram_read_enb,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  init_done
`ifdef RAM_REQ_CTRL_STATS_EN
   ,output logic [15:0]           wr_count,
    output logic [15:0]           rd_count
`else
`endif
);
    localparam int REQ_PW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int REQ_CW = $clog2(REQ_DEPTH + 1);
    localparam int RSP_PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int RSP_CW = $clog2(RSP_DEPTH + 1);
    localparam int RSP_SW = RSP_CW + 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                state;
    logic                  init_wr;
    logic [ADDR_WIDTH-1:0] init_addr;

    req_t                  req_mem [REQ_DEPTH];
    req_t                  req_head;
    logic [REQ_PW-1:0]     req_wp, req_rp;
    logic [REQ_CW-1:0]     req_cnt;
    logic                  req_push, req_pop;

    logic [DATA_WIDTH-1:0] rsp_mem [RSP_DEPTH];
    logic [RSP_PW-1:0]     rsp_wp, rsp_rp;
    logic [RSP_CW-1:0]     rsp_cnt;
    logic                  rsp_pop;

    logic                  rd_inflight;
    logic                  rd_credit;
    logic                  run_wr, run_rd;

    assign req_head      = req_mem[req_rp];
    assign bus.req_ready = (state == ST_RUN) && (req_cnt != REQ_CW'(REQ_DEPTH));
    assign req_push      = bus.req_valid && bus.req_ready;

    // A read may only issue if its response is guaranteed a slot in the response queue.
    assign rd_credit = ({1'b0, rsp_cnt} + {{RSP_CW{1'b0}}, rd_inflight}) < RSP_SW'(RSP_DEPTH);

    assign run_wr  = (state == ST_RUN) && (req_cnt != '0) && req_head.we;
    assign run_rd  = (state == ST_RUN) && (req_cnt != '0) && !req_head.we && rd_credit;
    assign req_pop = run_wr || run_rd;

    assign ram_write_enb = init_wr || run_wr;
    assign ram_read_enb  = run_rd;
    assign ram_address   = init_wr ? init_addr : (req_pop ? req_head.addr : '0);
    assign ram_data_in   = run_wr ? req_head.wdata : '0;

    assign bus.rsp_valid = (rsp_cnt != '0);
    assign bus.rsp_rdata = bus.rsp_valid ? rsp_mem[rsp_rp] : '0;
    assign rsp_pop       = bus.rsp_valid && bus.rsp_ready;

    // INIT sweeps every address once, starting the cycle after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_INIT;
            init_wr   <= 1'b0;
            init_addr <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            if (!init_wr) begin
                init_wr <= 1'b1;
            end else if (init_addr == '1) begin
                init_wr   <= 1'b0;
                init_addr <= '0;
                init_done <= 1'b1;
                state     <= ST_RUN;
            end else begin
                init_addr <= init_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_wp      <= '0;
            req_rp      <= '0;
            req_cnt     <= '0;
            rsp_wp      <= '0;
            rsp_rp      <= '0;
            rsp_cnt     <= '0;
            rd_inflight <= 1'b0;
        end else begin
            if (req_push)
                req_wp <= (req_wp == REQ_PW'(REQ_DEPTH - 1)) ? '0 : req_wp + 1'b1;
            if (req_pop)
                req_rp <= (req_rp == REQ_PW'(REQ_DEPTH - 1)) ? '0 : req_rp + 1'b1;
            case ({req_push, req_pop})
                2'b10:   req_cnt <= req_cnt + 1'b1;
                2'b01:   req_cnt <= req_cnt - 1'b1;
                default: ;
            endcase

            // RAM data returns one cycle after the read strobe.
            rd_inflight <= run_rd;
            if (rd_inflight)
                rsp_wp <= (rsp_wp == RSP_PW'(RSP_DEPTH - 1)) ? '0 : rsp_wp + 1'b1;
            if (rsp_pop)
                rsp_rp <= (rsp_rp == RSP_PW'(RSP_DEPTH - 1)) ? '0 : rsp_rp + 1'b1;
            case ({rd_inflight, rsp_pop})
                2'b10:   rsp_cnt <= rsp_cnt + 1'b1;
                2'b01:   rsp_cnt <= rsp_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (req_push)
            req_mem[req_wp] <= '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
        if (rd_inflight)
            rsp_mem[rsp_wp] <= ram_data_out;
    end

`ifdef RAM_REQ_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (run_wr && (wr_count != 16'hFFFF))
                wr_count <= wr_count + 16'd1;
            if (run_rd && (rd_count != 16'hFFFF))
                rd_count <= rd_count + 16'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Self-checking bench for ram_req_ctrl: RAM model, in-order scoreboard built from
// a reference memory image, directed scenarios plus a randomized traffic phase.
module tb_ram_req_ctrl;
    localparam int DW  = 8;
    localparam int AW  = 6;
    localparam int RQD = 4;
    localparam int RSD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ram_write_enb, ram_read_enb;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in, ram_data_out;
    logic          init_done;
`ifdef RAM_REQ_CTRL_STATS_EN
    logic [15:0]   wr_count, rd_count;
`endif

    ram_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REQ_DEPTH(RQD), .RSP_DEPTH(RSD)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .ram_write_enb(ram_write_enb),
        .ram_read_enb (ram_read_enb),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .init_done    (init_done)
`ifdef RAM_REQ_CTRL_STATS_EN
       ,.wr_count     (wr_count),
        .rd_count     (rd_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // RAM with one-cycle read latency; garbage on the data bus when not reading
    logic [DW-1:0] ram [1<<AW];
    always @(posedge clk) begin
        if (ram_write_enb) ram[ram_address] <= ram_data_in;
        ram_data_out <= ram_read_enb ? ram[ram_address] : DW'($urandom);
    end

    logic rnd = 1'b0, rnd_ready = 1'b1, rsp_dir = 1'b1;
    assign bus.rsp_ready = rnd ? rnd_ready : rsp_dir;
    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: memory image updated in acceptance order
    logic [DW-1:0] ref_mem [1<<AW];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] e;
    int n_rsp = 0, n_rd_issue = 0;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
        end else begin
            if (ram_write_enb || ram_read_enb) chk("strobe_excl", ram_write_enb && ram_read_enb, 0);
            if (ram_read_enb) n_rd_issue++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", bus.rsp_rdata, e);
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_we) ref_mem[bus.req_addr] = bus.req_wdata;
                else exp_q.push_back(ref_mem[bus.req_addr]);
            end
        end
    end

    // All tasks below are entered and left 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int acc);
        bit ok = 0;
        acc = -1;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin ok = 1; acc = cyc; end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        if (!ok) chk("req_timeout", 0, 1);
    endtask

    task automatic wait_rsp(input int acc, output int lat, output logic [DW-1:0] data);
        bit seen = 0;
        lat = -1; data = 'x;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin seen = 1; lat = cyc - acc; data = bus.rsp_rdata; end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (exp_q.size() != 0 || bus.rsp_valid); k++) idle(1);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_ram_we", ram_write_enb, 0);
        chk("rst_ram_re", ram_read_enb, 0);
        chk("rst_ram_addr", ram_address, 0);
        chk("rst_ram_din", ram_data_in, 0);
        chk("rst_init_done", init_done, 0);
    endtask

    task automatic init_check();
        int k = 0;
        @(negedge clk);
        while (!ram_write_enb && k < 5) begin @(negedge clk); k++; end
        for (int i = 0; i < (1<<AW); i++) begin
            chk("init_flags", {ram_write_enb, ram_read_enb, init_done, bus.rsp_valid, bus.req_ready},
                5'b10000);
            chk("init_addr", ram_address, i);
            chk("init_data", ram_data_in, 0);
            @(negedge clk);
        end
        chk("init_done", init_done, 1);
        chk("run_req_ready", bus.req_ready, 1);
        chk("init_stop", ram_write_enb, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int acc, lat, base_rsp, base_rd;
    logic [DW-1:0] data;

    initial begin
        for (int i = 0; i < (1<<AW); i++) ram[i] = DW'($urandom);
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs();
        @(posedge clk); #1;
        reset = 1'b1;
        init_check();

        // unwritten top address reads back as cleared
        do_req(1'b0, 6'h3F, '0, acc);
        wait_rsp(acc, lat, data);
        chk("rd_unwritten", data, 8'h00);

        // write then read same address; read latency
        do_req(1'b1, 6'h12, 8'hA5, acc);
        idle(3);
        base_rsp = n_rsp;
        do_req(1'b0, 6'h12, '0, acc);
        wait_rsp(acc, lat, data);
        chk("rd_latency", lat, 3);
        chk("rd_after_wr", data, 8'hA5);
        idle(4);
        chk("single_rsp", n_rsp - base_rsp, 1);

        // backpressure: only RSP_DEPTH reads may reach the RAM
        for (int i = 0; i < 8; i++) do_req(1'b1, AW'(i), DW'($urandom), acc);
        idle(2);
        rsp_dir = 1'b0;
        base_rd = n_rd_issue; base_rsp = n_rsp;
        for (int i = 0; i < 6; i++) do_req(1'b0, AW'($urandom_range(0, 7)), '0, acc);
        idle(8);
        chk("stall_rd_issued", n_rd_issue - base_rd, RSD);
        chk("stall_rsp_valid", bus.rsp_valid, 1);
        chk("stall_no_pop", n_rsp - base_rsp, 0);
        for (int i = 0; i < 2; i++) do_req(1'b0, AW'($urandom_range(0, 7)), '0, acc);
        @(negedge clk);
        chk("req_full_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        rsp_dir = 1'b1;
        drain();
        idle(2);
        chk("stall_drained", n_rsp - base_rsp, 8);
        chk("stall_all_issued", n_rd_issue - base_rd, 8);

        // randomized traffic with random response backpressure
        rnd = 1'b1;
        for (int i = 0; i < 60; i++)
            do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom), acc);
        rnd = 1'b0;
        drain();
        idle(2);
        chk("rnd_rsp_idle", bus.rsp_valid, 0);

        // reset while reads are in flight
        rsp_dir = 1'b0;
        do_req(1'b0, 6'h01, '0, acc);
        do_req(1'b0, 6'h02, '0, acc);
        idle(1);
        base_rsp = n_rsp;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outs();
        @(posedge clk); #1;
        reset = 1'b1;
        rsp_dir = 1'b1;
        init_check();
        idle(4);
        chk("rst_no_rsp", n_rsp - base_rsp, 0);
        chk("rst_rsp_idle", bus.rsp_valid, 0);

`ifdef RAM_REQ_CTRL_STATS_EN
        chk("stats_wr_init", wr_count, 0);
        chk("stats_rd_init", rd_count, 0);
        for (int i = 0; i < 5; i++) do_req(1'b1, AW'(i + 20), DW'($urandom), acc);
        for (int i = 0; i < 3; i++) do_req(1'b0, AW'(i + 20), '0, acc);
        drain();
        idle(2);
        chk("stats_wr", wr_count, 5);
        chk("stats_rd", rd_count, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
